// File: rtl/pattern_detector_if.sv
// Serial-input bus between the input stage and pattern_detector.
// With PATTERN_LOAD_EN defined, it also carries the runtime pattern-load lines.
`timescale 1ns/1ps
interface pattern_detector_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    localparam int SW = $clog2(PAT_W + 1);

    // There is no valid/ready handshake. en qualifies x and overlap at each rising edge.
    // F, S and match_count are registered and valid from the first edge after reset.
    logic             x;
    logic             en;
    logic             overlap;
    logic             F;
    logic [SW-1:0]    S;
    logic [CNT_W-1:0] match_count;
`ifdef PATTERN_LOAD_EN
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
`endif

    modport master (
        output x, en, overlap,
`ifdef PATTERN_LOAD_EN
        output pat_load, pat_in,
`endif
        input  F, S, match_count
    );

    modport slave (
        input  x, en, overlap,
`ifdef PATTERN_LOAD_EN
        input  pat_load, pat_in,
`endif
        output F, S, match_count
    );
endinterface

// File: rtl/pattern_detector.sv
// Moore serial pattern detector with prefix-match (KMP) state, overlap select and a saturating
// match counter. Define PATTERN_LOAD_EN to make the pattern loadable at runtime.
`timescale 1ns/1ps
module pattern_detector #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b0110,
    parameter int               CNT_W   = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    pattern_detector_if.slave bus
);
    localparam int               SW       = $clog2(PAT_W + 1);
    localparam int               TBL_N    = (PAT_W + 1) * 4;
    localparam logic [SW-1:0]    FULL     = SW'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Pattern bit i in time order. Bit 0 is the first bit expected.
    function automatic logic pat_bit(input logic [PAT_W-1:0] pat, input int i);
        logic [PAT_W-1:0] sh;
        sh = pat >> (PAT_W - 1 - i);
        return sh[0];
    endfunction

    // Length of the longest proper prefix of the whole pattern that is also its suffix.
    function automatic int fail_full(input logic [PAT_W-1:0] pat);
        int   best;
        logic ok;
        best = 0;
        for (int l = 1; l < PAT_W; l++) begin
            ok = 1'b1;
            for (int m = 0; m < PAT_W; m++) begin
                if (m < l) begin
                    if (pat_bit(pat, m) != pat_bit(pat, PAT_W - l + m)) ok = 1'b0;
                end
            end
            if (ok) best = l;
        end
        return best;
    endfunction

    // Next state: find the longest pattern prefix that ends the matched prefix followed by xb.
    function automatic int next_of(input logic [PAT_W-1:0] pat, input int k, input logic xb,
                                   input logic ov, input int fl);
        int   base;
        int   best;
        int   p;
        logic ok;
        logic b;
        if (k < PAT_W)  base = k;
        else if (ov)    base = fl;
        else            base = 0;
        best = 0;
        for (int j = 1; j <= PAT_W; j++) begin
            if (j <= base + 1) begin
                ok = 1'b1;
                for (int m = 0; m < PAT_W; m++) begin
                    if (m < j) begin
                        p = base + 1 - j + m;
                        b = (p < base) ? pat_bit(pat, p) : xb;
                        if (b != pat_bit(pat, m)) ok = 1'b0;
                    end
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    // The table is indexed by {state, x, overlap}. Each entry is SW bits wide.
    function automatic logic [TBL_N*SW-1:0] build_table(input logic [PAT_W-1:0] pat);
        logic [TBL_N*SW-1:0] t;
        int                  fl;
        t  = '0;
        fl = fail_full(pat);
        for (int k = 0; k <= PAT_W; k++) begin
            for (int xb = 0; xb < 2; xb++) begin
                for (int ov = 0; ov < 2; ov++) begin
                    t[((k * 2 + xb) * 2 + ov) * SW +: SW] =
                        SW'(next_of(pat, k, 1'(xb), 1'(ov), fl));
                end
            end
        end
        return t;
    endfunction

    function automatic logic [SW-1:0] lookup(input logic [TBL_N*SW-1:0] t, input int idx);
        logic [SW-1:0] r;
        r = '0;
        for (int i = 0; i < TBL_N; i++) begin
            if (i == idx) r = t[i * SW +: SW];
        end
        return r;
    endfunction

    logic [SW-1:0]    s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    tbl_nxt;
    int               idx;

`ifdef PATTERN_LOAD_EN
    logic [PAT_W-1:0] pat_q, pat_d;
`else
    localparam logic [TBL_N*SW-1:0] NEXT_TBL = build_table(PATTERN);
`endif

    always_comb begin
        idx = (int'(s_q) * 4) + (int'(bus.x) * 2) + int'(bus.overlap);
`ifdef PATTERN_LOAD_EN
        tbl_nxt = lookup(build_table(pat_q), idx);
`else
        tbl_nxt = lookup(NEXT_TBL, idx);
`endif
        // An illegal state recovers to 0 on the next enabled edge.
        if (s_q > FULL) tbl_nxt = '0;
    end

    always_comb begin
        s_d   = s_q;
        cnt_d = cnt_q;
`ifdef PATTERN_LOAD_EN
        pat_d = pat_q;
        if (bus.pat_load) begin
            pat_d = bus.pat_in;
            s_d   = '0;
        end else
`endif
        if (bus.en) begin
            s_d = tbl_nxt;
            if (tbl_nxt == FULL && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s_q   <= '0;
            cnt_q <= '0;
`ifdef PATTERN_LOAD_EN
            pat_q <= PATTERN;
`endif
        end else begin
            s_q   <= s_d;
            cnt_q <= cnt_d;
`ifdef PATTERN_LOAD_EN
            pat_q <= pat_d;
`endif
        end
    end

    assign bus.S           = s_q;
    assign bus.F           = (s_q == FULL);
    assign bus.match_count = cnt_q;
endmodule

// File: doc/pattern_detector.md
Name: pattern_detector

Overview:
Parametrised successor of the fixed 3-bit serial sequence detector. It is a Moore machine that scans a serial bit stream `x` for a PAT_W-bit pattern using prefix-match (KMP-style) state tracking. It supports selectable overlapping/non-overlapping detection, a sample-enable input, and a saturating match counter. It sits after the serial input stage and feeds match flags to downstream control logic.

Parameters:
PAT_W, 4, pattern length in bits (2..16).
PATTERN, 4'b0110, pattern to detect; PATTERN[PAT_W-1] is the first bit expected in time.
CNT_W, 8, width of the saturating match counter.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RESET  input  1  synchronous, active-high reset.
x  input  1  serial data bit, sampled when en=1.
en  input  1  sample enable; when 0, all state holds.
overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled each enabled cycle.
F  output  1  match flag; 1 exactly when S==PAT_W (Moore, decoded from the state register).
S  output  SW=$clog2(PAT_W+1)  current state = number of pattern bits currently matched (0..PAT_W).
match_count  output  CNT_W  number of matches since reset, saturating at 2^CNT_W-1.

Behaviour:
- Reset (RESET=1 at a rising edge): S=0, F=0, match_count=0. Reset has priority over en and over a match in progress.
- State meaning: S=k (k<PAT_W) means the last k sampled bits equal PATTERN[PAT_W-1 : PAT_W-k]. S=PAT_W means a full match ended on the last sample.
- Transition on an enabled cycle, for current state k and input bit x:
  - Define base = k if k<PAT_W.
  - If k==PAT_W: base = fail(PAT_W) when overlap=1, or base = 0 when overlap=0.
  - fail(j) = length of the longest proper prefix of the pattern that is also a suffix of the first j pattern bits.
  - Next state = longest j ≤ base+1 such that the last j bits (the matched prefix of length base followed by x) equal the first j pattern bits.
  - Equivalently, if x matches pattern bit base, next = base+1. Otherwise follow fail() from base until x matches or 0 is reached.
- The transition table is computed from PATTERN at elaboration. There is no runtime search loop; the next-state logic is combinational over (S, x, overlap).
- en=0: S and match_count hold, so F stays at its previous value.
- Latency: F rises in the cycle after the rising edge that samples the final pattern bit. F is 1 for as long as S==PAT_W, including while en=0.
- match_count increments by 1 on every enabled edge whose next state is PAT_W (re-entry from PAT_W also counts). At 2^CNT_W-1 it holds; it never wraps.
- States above PAT_W are unreachable. If S ever holds an illegal value, the next enabled edge sets S=0.
- Mid-stream change of overlap: it takes effect on the next enabled edge. It only matters when S==PAT_W.

Optional Feature:
PATTERN_LOAD_EN:
- Defined: adds inputs `pat_load` (1 bit) and `pat_in` (PAT_W bits), plus an internal pattern register that resets to PATTERN.
  - When pat_load=1 at an edge (and RESET=0), the register loads pat_in, S goes to 0, and match_count holds. pat_load has priority over en.
  - Failure values are then computed combinationally from the pattern register (cost: larger logic).
- Not defined: the ports are absent, and the pattern is the constant PATTERN with an elaboration-time table.

Test Plan:
- PAT_W=4, PATTERN=0110, overlap=1, en=1, stream 0,1,1,0,1,1,0 -> S=1,2,3,4,2,3,4; F=1 after the 4th and 7th bit; match_count=2.
- Same stream with overlap=0 -> S=1,2,3,4,0,0,1; F=1 only after the 4th bit; match_count=1.
- Stream 0,1,0,1,1,0 -> S=1,2,1,2,3,4. The mismatch falls back to S=1, not 0; match_count=1.
- Stream 0,1,1; then RESET=1 for one cycle; then 0 -> S=0 after reset, then S=1; F never 1; match_count=0.
- Stream 0,1 with en=1, then en=0 for 3 cycles with x toggling, then en=1 with 1,0 -> S holds at 2 during en=0; match after the 4th enabled bit; F stays 1 while en=0 afterwards.
- CNT_W=2, overlap=1, stream 0110 followed by 110 repeated 5 times -> match_count goes 1,2,3,3,3,3; F pulses on every match.
